ocp_conv_engine_seq: RTL and testbench

//   Multi-input-channel 3x3 conv engine with internal channel sequencing and on-chip partial-sum storage.

---
 rtl/ocp_conv_engine_seq_if.sv | 34 +++
 rtl/ocp_conv_engine_seq.sv | 192 +++++++++++++++++++
 tb/tb_ocp_conv_engine_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ocp_conv_engine_seq_if.sv
// Bus bundle for the sequenced conv engine: job control, window stream,
// weight ROM port and result stream. The engine uses the slave side.
interface ocp_conv_engine_seq_if #(
  parameter int OUT_CHANNELS = 4,
  parameter int IN_CHANNELS  = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int WGT_WIDTH    = 8,
  parameter int OUT_WIDTH    = 20
) ();
  localparam int CW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

  logic                              start;
  logic                              busy;
  logic                              done;
  logic [9*DATA_WIDTH-1:0]           win_in;
  logic                              win_valid;
  logic                              win_ready;
  logic [CW-1:0]                     rom_addr;
  logic [OUT_CHANNELS*9*WGT_WIDTH-1:0] rom_q;
  logic [OUT_CHANNELS*OUT_WIDTH-1:0] dout;
  logic                              dout_valid;
  logic                              dout_ready;
  logic                              dout_last;

  modport slave (
    input  start, win_in, win_valid, rom_q, dout_ready,
    output busy, done, win_ready, rom_addr, dout, dout_valid, dout_last
  );

  modport master (
    output start, win_in, win_valid, rom_q, dout_ready,
    input  busy, done, win_ready, rom_addr, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/ocp_conv_engine_seq.sv
// Multi-input-channel 3x3 convolution engine. Walks the input channels one
// frame at a time, fetching each channel's weights from a 1-cycle ROM,
// keeps per-pixel partial sums on chip, and streams the final (optionally
// ReLU'd) results of the last channel under valid/ready.
module ocp_conv_engine_seq #(
  parameter int OUT_CHANNELS    = 4,
  parameter int IN_CHANNELS     = 8,
  parameter int NUM_PIX         = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int WGT_WIDTH       = 8,
  parameter int OUT_WIDTH       = 20,
  parameter int INPUT_IS_SIGNED = 0,
  parameter int RELU_EN         = 1
) (
  input logic                clk,
  input logic                rst_n,
  ocp_conv_engine_seq_if.slave bus
);
  localparam int CW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int LW = 9 * WGT_WIDTH;
  localparam int VW = OUT_CHANNELS * OUT_WIDTH;
  localparam logic [CW-1:0] LAST_CH  = CW'(IN_CHANNELS - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_D = 3'd2,
    S_RUN    = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_ch;
  logic [PW-1:0]                r_pix;
  logic                         r_busy;
  logic                         r_done;
  logic [CW-1:0]                r_rom_addr;
  logic [OUT_CHANNELS*LW-1:0]   r_wgt;
  logic [VW-1:0]                r_dout;
  logic                         r_dout_valid;
  logic                         r_dout_last;
  logic [VW-1:0]                r_acc [NUM_PIX];

  logic                         w_last_ch;
  logic                         w_pix_wrap;
  logic                         w_win_ready;
  logic                         w_accept;
  logic                         w_out_hs;
  logic [VW-1:0]                w_acc_rd;
  logic [VW-1:0]                w_sum;
  logic [VW-1:0]                w_res;

  // Window element widened to the accumulator width.
  function automatic logic [OUT_WIDTH-1:0] ext_win(input logic [DATA_WIDTH-1:0] x);
    if (INPUT_IS_SIGNED != 0) begin
      return {{(OUT_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    end else begin
      return {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, x};
    end
  endfunction

  // Weights are always two's complement.
  function automatic logic [OUT_WIDTH-1:0] ext_wgt(input logic [WGT_WIDTH-1:0] x);
    return {{(OUT_WIDTH-WGT_WIDTH){x[WGT_WIDTH-1]}}, x};
  endfunction

  // 9-tap dot product for one output lane, wrapping modulo 2^OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] lane_mac(input logic [9*DATA_WIDTH-1:0] win,
                                                    input logic [LW-1:0] wgt);
    logic [OUT_WIDTH-1:0] acc;
    acc = {OUT_WIDTH{1'b0}};
    for (int k = 0; k < 9; k++) begin
      acc = acc + ext_win(win[k*DATA_WIDTH +: DATA_WIDTH]) * ext_wgt(wgt[k*WGT_WIDTH +: WGT_WIDTH]);
    end
    return acc;
  endfunction

  // Clamp negatives to zero on the final result only.
  function automatic logic [OUT_WIDTH-1:0] relu(input logic [OUT_WIDTH-1:0] x);
    if ((RELU_EN != 0) && x[OUT_WIDTH-1]) begin
      return {OUT_WIDTH{1'b0}};
    end else begin
      return x;
    end
  endfunction

  assign w_last_ch  = (r_ch == LAST_CH);
  assign w_pix_wrap = (r_pix == LAST_PIX);
  // On the last channel a window is only taken when the output slot can be refilled.
  assign w_win_ready = (r_state == S_RUN) && (!w_last_ch || !r_dout_valid || bus.dout_ready);
  assign w_accept    = w_win_ready && bus.win_valid;
  assign w_out_hs    = r_dout_valid && bus.dout_ready;
  // The first channel starts from zero so leftovers from an earlier job are never seen.
  assign w_acc_rd    = (r_ch == {CW{1'b0}}) ? {VW{1'b0}} : r_acc[r_pix];

  for (genvar oc = 0; oc < OUT_CHANNELS; oc++) begin : g_lane
    assign w_sum[oc*OUT_WIDTH +: OUT_WIDTH] = lane_mac(bus.win_in, r_wgt[oc*LW +: LW])
                                              + w_acc_rd[oc*OUT_WIDTH +: OUT_WIDTH];
    assign w_res[oc*OUT_WIDTH +: OUT_WIDTH] = relu(w_sum[oc*OUT_WIDTH +: OUT_WIDTH]);
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.win_ready  = w_win_ready;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_last  = r_dout_last;

  // Job sequencer: channel/pixel counters, weight fetch and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ch         <= {CW{1'b0}};
      r_pix        <= {PW{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rom_addr   <= {CW{1'b0}};
      r_wgt        <= {(OUT_CHANNELS*LW){1'b0}};
      r_dout       <= {VW{1'b0}};
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_out_hs) begin
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ch       <= {CW{1'b0}};
            r_pix      <= {PW{1'b0}};
            r_rom_addr <= {CW{1'b0}};
            r_busy     <= 1'b1;
            r_state    <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          r_rom_addr <= r_ch;
          r_state    <= S_LOAD_D;
        end
        S_LOAD_D: begin
          r_wgt   <= bus.rom_q;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last_ch) begin
              // Overrides the handshake clear above: back-to-back reload.
              r_dout       <= w_res;
              r_dout_valid <= 1'b1;
              r_dout_last  <= w_pix_wrap;
            end
            if (w_pix_wrap) begin
              r_pix <= {PW{1'b0}};
              if (w_last_ch) begin
                r_state <= S_FLUSH;
              end else begin
                r_ch       <= r_ch + 1'b1;
                r_rom_addr <= r_ch + 1'b1;
                r_state    <= S_LOAD_A;
              end
            end else begin
              r_pix <= r_pix + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (w_out_hs) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Partial-sum store; contents need no reset since channel 0 overwrites every pixel.
  always_ff @(posedge clk) begin
    if (w_accept && !w_last_ch) begin
      r_acc[r_pix] <= w_sum;
    end
  end
endmodule

// File: tb/tb_ocp_conv_engine_seq.sv
// Directed bench for ocp_conv_engine_seq (2 out ch, 2 in ch, 4 pixels).
// Two instances share all inputs: one with ReLU, one without.
module tb_ocp_conv_engine_seq;
  localparam int OC = 2;
  localparam int IC = 2;
  localparam int NP = 4;

  typedef struct {
    logic                   wmode;   // 0: every element = wval, 1: element = pix+1
    logic [7:0]             wval;
    logic [1:0][1:0][7:0]   wgt;     // [in ch][out ch], same for all 9 taps
    logic [3:0][1:0][19:0]  exp_r;   // [pix][lane], ReLU instance
    logic [3:0][1:0][19:0]  exp_n;   // [pix][lane], no-ReLU instance
  } vec_t;

  vec_t tbl [3];
  logic clk;
  logic rst_n;
  logic [1:0][1:0][7:0] cur_wgt;
  int checks;
  int failures;

  ocp_conv_engine_seq_if #(.OUT_CHANNELS(OC), .IN_CHANNELS(IC), .DATA_WIDTH(8),
                           .WGT_WIDTH(8), .OUT_WIDTH(20)) if0 ();
  ocp_conv_engine_seq_if #(.OUT_CHANNELS(OC), .IN_CHANNELS(IC), .DATA_WIDTH(8),
                           .WGT_WIDTH(8), .OUT_WIDTH(20)) if1 ();

  ocp_conv_engine_seq #(.OUT_CHANNELS(OC), .IN_CHANNELS(IC), .NUM_PIX(NP), .DATA_WIDTH(8),
                        .WGT_WIDTH(8), .OUT_WIDTH(20), .INPUT_IS_SIGNED(0), .RELU_EN(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(if0));
  ocp_conv_engine_seq #(.OUT_CHANNELS(OC), .IN_CHANNELS(IC), .NUM_PIX(NP), .DATA_WIDTH(8),
                        .WGT_WIDTH(8), .OUT_WIDTH(20), .INPUT_IS_SIGNED(0), .RELU_EN(0))
    dut_nr (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if1.start      = if0.start;
  assign if1.win_in     = if0.win_in;
  assign if1.win_valid  = if0.win_valid;
  assign if1.rom_q      = if0.rom_q;
  assign if1.dout_ready = if0.dout_ready;

  always #5 clk = ~clk;

  // Weight word for one ROM address.
  function automatic logic [143:0] mk_rom(input logic a);
    logic [143:0] r;
    r = '0;
    for (int oc = 0; oc < OC; oc++)
      for (int k = 0; k < 9; k++)
        r[(oc*9+k)*8 +: 8] = cur_wgt[a][oc];
    return r;
  endfunction

  // Synchronous ROM, 1-cycle read latency.
  always @(posedge clk) if0.rom_q <= mk_rom(if0.rom_addr);

  function automatic logic [71:0] mkwin(input int e, input int p);
    logic [71:0] w;
    logic [7:0]  pv;
    pv = 8'(p + 1);
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = tbl[e].wmode ? pv : tbl[e].wval;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, 64'(if0.busy), 64'd0);
    chk({nm, "_done"}, 64'(if0.done), 64'd0);
    chk({nm, "_win_ready"}, 64'(if0.win_ready), 64'd0);
    chk({nm, "_rom_addr"}, 64'(if0.rom_addr), 64'd0);
    chk({nm, "_dout"}, 64'(if0.dout), 64'd0);
    chk({nm, "_dout_valid"}, 64'(if0.dout_valid), 64'd0);
    chk({nm, "_dout_last"}, 64'(if0.dout_last), 64'd0);
  endtask

  // Run one full job from table entry e. Optionally stall dout_ready for
  // stall_len cycles once output stall_at is presented, and pulse start
  // again at loop cycle extra_start (-1: never). Called at a falling edge.
  task automatic run_job(input int e, input int stall_at, input int stall_len, input int extra_start);
    int widx, oidx, done_cnt, last_hs, load_cnt, stall_left;
    int hs [4];
    int rseq [$];
    logic stalled;
    logic [39:0] held;
    widx = 0; oidx = 0; done_cnt = 0; last_hs = -10; stall_left = 0; stalled = 1'b0;
    held = '0;
    cur_wgt = tbl[e].wgt;
    if0.start = 1'b1;
    if0.win_valid = 1'b1;
    if0.win_in = mkwin(e, 0);
    if0.dout_ready = 1'b1;
    #1;
    chk("idle_win_ready", 64'(if0.win_ready), 64'd0);
    @(negedge clk);
    load_cnt = 2;
    for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
      if0.start = (cyc == extra_start);
      if0.win_valid = (widx < IC*NP);
      if0.win_in = mkwin(e, widx % NP);
      if (if0.dout_valid && oidx == stall_at && !stalled && stall_len > 0) begin
        stalled = 1'b1;
        stall_left = stall_len;
        held = if0.dout;
      end
      if0.dout_ready = (stall_left == 0);
      #1;
      if (rseq.size() == 0 || rseq[rseq.size()-1] != int'(if0.rom_addr)) rseq.push_back(int'(if0.rom_addr));
      chk("busy", 64'(if0.busy), 64'(!if0.done));
      if (load_cnt > 0) begin
        chk("load_win_ready", 64'(if0.win_ready), 64'd0);
        load_cnt--;
      end
      if (widx >= IC*NP) chk("flush_win_ready", 64'(if0.win_ready), 64'd0);
      if (stall_left > 0) begin
        chk("stall_win_ready", 64'(if0.win_ready), 64'd0);
        chk("stall_hold_dout", 64'(if0.dout), 64'(held));
        chk("stall_valid", 64'(if0.dout_valid), 64'd1);
        stall_left--;
      end
      if (if0.done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_hs + 1));
      end
      if (if0.dout_valid && if0.dout_ready) begin
        if (oidx < NP) begin
          chk("dout_lane0_relu", 64'(if0.dout[19:0]), 64'(tbl[e].exp_r[oidx][0]));
          chk("dout_lane1_relu", 64'(if0.dout[39:20]), 64'(tbl[e].exp_r[oidx][1]));
          chk("dout_lane0_norelu", 64'(if1.dout[19:0]), 64'(tbl[e].exp_n[oidx][0]));
          chk("dout_lane1_norelu", 64'(if1.dout[39:20]), 64'(tbl[e].exp_n[oidx][1]));
          chk("dout_last", 64'(if0.dout_last), 64'(oidx == NP-1));
          hs[oidx] = cyc;
        end else begin
          chk("extra_output", 64'(oidx), 64'(NP-1));
        end
        last_hs = cyc;
        oidx++;
      end
      if (if0.win_valid && if0.win_ready) begin
        widx++;
        if (widx % NP == 0 && widx < IC*NP) load_cnt = 2;
      end
      @(negedge clk);
    end
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("output_count", 64'(oidx), 64'(NP));
    chk("window_count", 64'(widx), 64'(IC*NP));
    chk("rom_addr_seq_len", 64'(rseq.size()), 64'd2);
    if (rseq.size() == 2) begin
      chk("rom_addr_seq0", 64'(rseq[0]), 64'd0);
      chk("rom_addr_seq1", 64'(rseq[1]), 64'd1);
    end
    if (oidx == NP && (stall_len == 0 || stall_at == 0))
      chk("back_to_back", 64'(hs[NP-1] - hs[0]), 64'(NP-1));
    if0.start = 1'b0;
    if0.win_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_done", 64'(if0.done), 64'd0);
      chk("post_busy", 64'(if0.busy), 64'd0);
      chk("idle_win_ready", 64'(if0.win_ready), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    int widx;
    logic got;
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    if0.start = 1'b0;
    if0.win_in = '0;
    if0.win_valid = 1'b0;
    if0.dout_ready = 1'b0;
    cur_wgt = '0;

    // test 1: ones everywhere -> 18
    tbl[0].wmode = 1'b0; tbl[0].wval = 8'd1; tbl[0].wgt = {4{8'd1}};
    tbl[0].exp_r = {8{20'd18}}; tbl[0].exp_n = {8{20'd18}};
    // test 2: 5 * -1 * 9 taps * 2 channels = -90
    tbl[1].wmode = 1'b0; tbl[1].wval = 8'd5; tbl[1].wgt = {4{8'hFF}};
    tbl[1].exp_r = {8{20'd0}}; tbl[1].exp_n = {8{20'hFFFA6}};
    // test 3: oc0 weights 1,2 / oc1 weights 2,4 over channels; elements pix+1
    tbl[2].wmode = 1'b1; tbl[2].wval = 8'd0; tbl[2].wgt = {8'd4, 8'd2, 8'd2, 8'd1};
    tbl[2].exp_r = {20'd216, 20'd108, 20'd162, 20'd81, 20'd108, 20'd54, 20'd54, 20'd27};
    tbl[2].exp_n = {20'd216, 20'd108, 20'd162, 20'd81, 20'd108, 20'd54, 20'd54, 20'd27};

    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int e = 0; e < 3; e++) run_job(e, -1, 0, -1);
    // backpressure on the first final output, then streaming
    run_job(2, 0, 5, -1);
    // stray start while busy, and a stall held in FLUSH
    run_job(0, 3, 5, 4);

    // reset in the middle of the last channel with an output pending
    cur_wgt = tbl[2].wgt;
    if0.start = 1'b1;
    if0.win_valid = 1'b0;
    @(negedge clk);
    if0.start = 1'b0;
    widx = 0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if0.win_valid = 1'b1;
      if0.win_in = mkwin(2, widx % NP);
      if0.dout_ready = 1'b0;
      #1;
      if (if0.dout_valid) got = 1'b1;
      else if (if0.win_ready) widx++;
      if (!got) @(negedge clk);
    end
    chk("pre_reset_valid", 64'(got), 64'd1);
    chk("pre_reset_windows", 64'(widx), 64'(NP+1));
    chk("pre_reset_dout", 64'(if0.dout), {24'd0, 20'd54, 20'd27});
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    chk("midrun_reset_dout_norelu", 64'(if1.dout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if0.win_valid = 1'b0;
    if0.dout_ready = 1'b1;
    @(negedge clk);
    run_job(0, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
